// File: rtl/qtcore_scan_pkg.sv
// Shared definitions for the qtcore scan-chain loader: chain geometry,
// FSM state encoding and counter sizing.
package qtcore_scan_pkg;

    localparam int SCAN_CHAIN_BITS = 160;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        EMIT,
        SETTLE
    } state_t;

    // Width of a counter that has to hold the values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SCAN_BYTE_CNT_W = cnt_width(SCAN_CHAIN_BITS / 8);

endpackage

// File: rtl/qtcore_scan_loader_shifter.sv
// Byte-wide shifter: parallel load / MSB-first serial out, serial in /
// parallel out, with a bit counter that flags the eighth shift.
module scan_byte_shifter (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_shift,
    input  logic       i_sin,
    output logic [7:0] o_data,
    output logic       o_sout,
    output logic       o_last
);

    logic [7:0] r_byte;
    logic [2:0] r_bit_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_byte    <= '0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_byte    <= i_data;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_byte    <= {r_byte[6:0], i_sin};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    assign o_data = r_byte;
    assign o_sout = r_byte[7];
    assign o_last = (r_bit_cnt == 3'd7);

endmodule

// File: rtl/qtcore_scan_loader.sv
// Byte-stream front end for the qtcore scan chain: each frame shifts a new
// image in, returns the old chain contents and holds the processor meanwhile.
module qtcore_scan_loader
    import qtcore_scan_pkg::*;
#(
    parameter int CHAIN_BITS    = SCAN_CHAIN_BITS,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       start_in,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       scan_enable_out,
    output logic       scan_shift_out,
    output logic       scan_data_out,
    input  logic       scan_data_in,
    output logic       busy_out,
    output logic       done_out,
    output logic       proc_hold_out
);

    localparam int N_BYTES    = CHAIN_BITS / 8;
    localparam int BYTE_CNT_W = cnt_width(N_BYTES);
    localparam int SETTLE_W   = cnt_width(SETTLE_CYCLES);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE   = BYTE_CNT_W'(N_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] BYTE_ONE    = BYTE_CNT_W'(1);
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_ONE  = SETTLE_W'(1);

    if ((CHAIN_BITS % 8) != 0 || CHAIN_BITS < 8) begin : g_bad_chain
        $error("qtcore_scan_loader: CHAIN_BITS must be a positive multiple of 8");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("qtcore_scan_loader: SETTLE_CYCLES must be at least 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [SETTLE_W-1:0]   r_settle_cnt;

    logic w_load;
    logic w_shift;
    logic w_out_hs;
    logic w_last_bit;
    logic w_sout;
    logic [7:0] w_byte;

    logic w_in_ready;
    logic w_scan_en;
    logic w_shift_stb;
    logic w_out_valid;
    logic w_busy;
    logic w_done;

    assign w_load   = (r_state == LOAD) && in_valid && in_ready;
    assign w_shift  = (r_state == SHIFT);
    assign w_out_hs = (r_state == EMIT) && out_valid && out_ready;

    // The chain shifts on the same edge that samples scan_data_in, so the
    // captured bit is the tail value present during the strobe cycle.
    scan_byte_shifter u_shifter (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .i_load   (w_load),
        .i_data   (in_data),
        .i_shift  (w_shift),
        .i_sin    (scan_data_in),
        .o_data   (w_byte),
        .o_sout   (w_sout),
        .o_last   (w_last_bit)
    );

    assign out_data      = w_byte;
    assign scan_data_out = w_sout;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start_in)   w_state_nxt = LOAD;
            LOAD:    if (w_load)     w_state_nxt = SHIFT;
            SHIFT:   if (w_last_bit) w_state_nxt = EMIT;
            EMIT:    if (w_out_hs)   w_state_nxt = (r_byte_cnt == LAST_BYTE) ? SETTLE : LOAD;
            SETTLE:  if (r_settle_cnt == SETTLE_LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // changes on the same edge as the state it describes.
    always_comb begin
        w_in_ready  = (w_state_nxt == LOAD);
        w_scan_en   = (w_state_nxt != IDLE);
        w_shift_stb = (w_state_nxt == SHIFT);
        w_out_valid = (w_state_nxt == EMIT);
        w_busy      = (w_state_nxt != IDLE);
        w_done      = (r_state == SETTLE) && (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state         <= IDLE;
            in_ready        <= 1'b0;
            scan_enable_out <= 1'b0;
            scan_shift_out  <= 1'b0;
            out_valid       <= 1'b0;
            busy_out        <= 1'b0;
            proc_hold_out   <= 1'b0;
            done_out        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            in_ready        <= w_in_ready;
            scan_enable_out <= w_scan_en;
            scan_shift_out  <= w_shift_stb;
            out_valid       <= w_out_valid;
            busy_out        <= w_busy;
            proc_hold_out   <= w_busy;
            done_out        <= w_done;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_byte_cnt   <= '0;
            r_settle_cnt <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_byte_cnt <= '0;
            end else if (w_out_hs && (r_byte_cnt != LAST_BYTE)) begin
                r_byte_cnt <= r_byte_cnt + BYTE_ONE;
            end
            if (r_state == SETTLE) begin
                r_settle_cnt <= r_settle_cnt + SETTLE_ONE;
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_qtcore_scan_loader.sv
// Directed bench for qtcore_scan_loader with a behavioural 160-bit chain.
module tb_qtcore_scan_loader;

    localparam int NB = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       scan_en;
    logic       scan_shift;
    logic       scan_dout;
    logic       scan_din;
    logic       busy;
    logic       done;
    logic       hold;

    always #5 clk = ~clk;

    qtcore_scan_loader dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .start_in        (start),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .scan_enable_out (scan_en),
        .scan_shift_out  (scan_shift),
        .scan_data_out   (scan_dout),
        .scan_data_in    (scan_din),
        .busy_out        (busy),
        .done_out        (done),
        .proc_hold_out   (hold)
    );

    // Behavioural scan chain: shifts toward the MSB, tail is bit 159.
    logic [159:0] model = '0;
    logic [159:0] preload_val = '0;
    logic         preload_req = 1'b0;
    int           strobes = 0;

    always @(posedge clk) begin
        if (preload_req) model <= preload_val;
        else if (scan_en && scan_shift) model <= {model[158:0], scan_dout};
        if (scan_shift) strobes <= strobes + 1;
    end
    assign scan_din = model[159];

    int checks = 0;
    int failures = 0;

    logic [7:0] tx [NB];
    logic [7:0] rx [NB];
    int rx_cnt, tx_idx, done_cnt, done_cycle, timed_out;
    int gap_cnt, gap_viol, stall_cnt, stall_viol, busy_mid, strobe_base;
    int aborted;
    logic ab_en, ab_busy, ab_done, ab_hold;
    logic end_en, end_busy, end_hold;

    function automatic logic [159:0] pack_tx();
        logic [159:0] v;
        for (int i = 0; i < NB; i++) v[159 - 8*i -: 8] = tx[i];
        return v;
    endfunction

    task automatic preload(input logic [159:0] v);
        @(negedge clk);
        preload_val = v;
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
    endtask

    // Drives one frame; the negative values disable the optional events.
    task automatic run_frame(input int gap_byte, input int stall_byte,
                             input int mid_byte, input int abort_byte);
        logic [7:0] stall_data;
        int mid_state;
        int n;
        stall_data = 8'h00;
        mid_state = 0;
        rx_cnt = 0; tx_idx = 0; done_cnt = 0; done_cycle = -1; timed_out = 0;
        gap_cnt = 0; gap_viol = 0; stall_cnt = 0; stall_viol = 0; busy_mid = -1;
        aborted = 0; strobe_base = strobes;
        for (int i = 0; i < NB; i++) rx[i] = 8'hxx;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (mid_state == 1) begin busy_mid = int'(busy); mid_state = 2; end
            if (done) begin
                done_cnt++; done_cycle = n;
                end_en = scan_en; end_busy = busy; end_hold = hold;
                break;
            end
            if (n > 600) begin timed_out = 1; break; end
            if (abort_byte >= 0 && rx_cnt == abort_byte && in_ready) begin
                rst_n = 1'b0; in_valid = 1'b0;
                @(negedge clk);
                ab_en = scan_en; ab_busy = busy; ab_done = done; ab_hold = hold;
                rst_n = 1'b1; aborted = 1;
                repeat (3) begin
                    @(negedge clk);
                    if (done) ab_done = 1'b1;
                end
                break;
            end
            in_valid = 1'b0;
            if (tx_idx < NB) begin
                if (tx_idx == gap_byte && in_ready && gap_cnt < 3) begin
                    gap_cnt++;
                    if (!scan_en || scan_shift) gap_viol++;
                end else begin
                    in_valid = 1'b1;
                    in_data = tx[tx_idx];
                    if (in_ready) tx_idx++;
                end
            end
            if (mid_state == 0 && tx_idx == mid_byte && scan_shift) begin
                start = 1'b1; mid_state = 1;
            end
            out_ready = 1'b1;
            if (out_valid) begin
                if (rx_cnt == stall_byte && stall_cnt < 5) begin
                    if (stall_cnt == 0) stall_data = out_data;
                    else if (out_data !== stall_data) stall_viol++;
                    if (scan_shift) stall_viol++;
                    stall_cnt++;
                    out_ready = 1'b0;
                end else if (rx_cnt < NB) begin
                    rx[rx_cnt] = out_data;
                    rx_cnt++;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        int viol;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (scan_en !== 1'b0) begin failures++; $display("FAIL reset_scan_en got=%b exp=0", scan_en); end
        checks++; if (scan_shift !== 1'b0) begin failures++; $display("FAIL reset_scan_shift got=%b exp=0", scan_shift); end
        checks++; if (scan_dout !== 1'b0) begin failures++; $display("FAIL reset_scan_dout got=%b exp=0", scan_dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", hold); end
        rst_n = 1'b1; out_ready = 1'b1;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (scan_en !== 1'b0 || busy !== 1'b0) viol++;
        end
        checks++; if (viol != 0) begin failures++; $display("FAIL idle_no_start violations got=%0d exp=0", viol); end
    endtask

    task automatic test_load();
        logic [159:0] exp_chain;
        int nz;
        tx[0] = 8'hF0;
        for (int i = 1; i < NB - 1; i++) tx[i] = 8'(i * 13 + 1);
        tx[NB-1] = 8'hE4;
        preload('0);
        run_frame(-1, -1, -1, -1);
        exp_chain = pack_tx();
        nz = 0;
        for (int i = 0; i < NB; i++) if (rx[i] !== 8'h00) nz++;
        checks++; if (timed_out != 0) begin failures++; $display("FAIL load_timeout got=%0d exp=0", timed_out); end
        checks++; if (model[159:152] !== 8'hF0) begin failures++; $display("FAIL load_first_byte got=%h exp=f0", model[159:152]); end
        checks++; if (model[7:0] !== 8'hE4) begin failures++; $display("FAIL load_last_byte got=%h exp=e4", model[7:0]); end
        checks++; if (model !== exp_chain) begin failures++; $display("FAIL load_chain got=%h exp=%h", model, exp_chain); end
        checks++; if (rx_cnt != NB || nz != 0) begin failures++; $display("FAIL load_out_bytes count=%0d nonzero=%0d exp=20/0", rx_cnt, nz); end
        checks++; if (strobes - strobe_base != 160) begin failures++; $display("FAIL load_strobes got=%0d exp=160", strobes - strobe_base); end
        checks++; if (done_cnt != 1 || done_cycle != 202) begin failures++; $display("FAIL load_done pulses=%0d cycle=%0d exp=1/202", done_cnt, done_cycle); end
        checks++; if (end_en !== 1'b0 || end_busy !== 1'b0 || end_hold !== 1'b0) begin
            failures++; $display("FAIL load_release en=%b busy=%b hold=%b exp=000", end_en, end_busy, end_hold);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL load_done_width got=%b exp=0", done); end
    endtask

    task automatic test_round_trip();
        logic [159:0] pre;
        int nz;
        pre = '0;
        pre[23:0] = 24'h01E009;
        pre[159:152] = 8'hF0;
        for (int i = 0; i < NB; i++) tx[i] = 8'(8'hA0 + i);
        preload(pre);
        run_frame(-1, -1, -1, -1);
        nz = 0;
        for (int i = 1; i < NB - 3; i++) if (rx[i] !== 8'h00) nz++;
        checks++; if (rx[0] !== 8'hF0) begin failures++; $display("FAIL rt_first got=%h exp=f0", rx[0]); end
        checks++; if (rx[17] !== 8'h01) begin failures++; $display("FAIL rt_acc got=%h exp=01", rx[17]); end
        checks++; if (rx[18] !== 8'hE0) begin failures++; $display("FAIL rt_ir got=%h exp=e0", rx[18]); end
        checks++; if (rx[19] !== 8'h09) begin failures++; $display("FAIL rt_pc_state got=%h exp=09", rx[19]); end
        checks++; if (nz != 0) begin failures++; $display("FAIL rt_middle nonzero=%0d exp=0", nz); end
        checks++; if (model !== pack_tx()) begin failures++; $display("FAIL rt_chain got=%h exp=%h", model, pack_tx()); end
    endtask

    task automatic test_backpressure();
        logic [159:0] pre;
        int bad;
        for (int i = 0; i < NB; i++) pre[159 - 8*i -: 8] = 8'(8'h30 + i);
        for (int i = 0; i < NB; i++) tx[i] = 8'(8'h5A ^ i);
        preload(pre);
        run_frame(-1, 4, -1, -1);
        bad = 0;
        for (int i = 0; i < NB; i++) if (rx[i] !== 8'(8'h30 + i)) bad++;
        checks++; if (stall_cnt != 5 || stall_viol != 0) begin failures++; $display("FAIL bp_stall cycles=%0d violations=%0d exp=5/0", stall_cnt, stall_viol); end
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_data wrong_bytes=%0d exp=0 byte4=%h exp=34", bad, rx[4]); end
        checks++; if (done_cycle != 207) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=207", done_cycle); end
        checks++; if (strobes - strobe_base != 160) begin failures++; $display("FAIL bp_strobes got=%0d exp=160", strobes - strobe_base); end
        checks++; if (model !== pack_tx()) begin failures++; $display("FAIL bp_chain got=%h exp=%h", model, pack_tx()); end
    endtask

    task automatic test_gaps_and_start();
        logic [159:0] pre;
        int bad;
        for (int i = 0; i < NB; i++) pre[159 - 8*i -: 8] = 8'(8'hC0 ^ (i * 7));
        for (int i = 0; i < NB; i++) tx[i] = 8'(8'h0F + i * 3);
        preload(pre);
        run_frame(2, -1, 6, -1);
        bad = 0;
        for (int i = 0; i < NB; i++) if (rx[i] !== 8'(8'hC0 ^ (i * 7))) bad++;
        checks++; if (gap_cnt != 3 || gap_viol != 0) begin failures++; $display("FAIL gap_load cycles=%0d violations=%0d exp=3/0", gap_cnt, gap_viol); end
        checks++; if (busy_mid != 1) begin failures++; $display("FAIL mid_start_busy got=%0d exp=1", busy_mid); end
        checks++; if (done_cnt != 1 || done_cycle != 205) begin failures++; $display("FAIL gap_done pulses=%0d cycle=%0d exp=1/205", done_cnt, done_cycle); end
        checks++; if (bad != 0) begin failures++; $display("FAIL gap_data wrong_bytes=%0d exp=0", bad); end
        checks++; if (model !== pack_tx()) begin failures++; $display("FAIL gap_chain got=%h exp=%h", model, pack_tx()); end
    endtask

    task automatic test_reset_mid_frame();
        logic [159:0] pre;
        int bad;
        for (int i = 0; i < NB; i++) tx[i] = 8'(8'h81 + i);
        preload('0);
        run_frame(-1, -1, -1, 3);
        checks++; if (aborted != 1) begin failures++; $display("FAIL abort_reached got=%0d exp=1", aborted); end
        checks++; if (ab_en !== 1'b0 || ab_busy !== 1'b0 || ab_hold !== 1'b0) begin
            failures++; $display("FAIL abort_outputs en=%b busy=%b hold=%b exp=000", ab_en, ab_busy, ab_hold);
        end
        checks++; if (ab_done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", ab_done); end
        checks++; if (strobes - strobe_base != 24) begin failures++; $display("FAIL abort_strobes got=%0d exp=24", strobes - strobe_base); end
        for (int i = 0; i < NB; i++) pre[159 - 8*i -: 8] = 8'(8'h11 * (i % 15));
        for (int i = 0; i < NB; i++) tx[i] = 8'(8'hF7 - i);
        preload(pre);
        run_frame(-1, -1, -1, -1);
        bad = 0;
        for (int i = 0; i < NB; i++) if (rx[i] !== 8'(8'h11 * (i % 15))) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL refresh_data wrong_bytes=%0d exp=0", bad); end
        checks++; if (done_cnt != 1 || done_cycle != 202) begin failures++; $display("FAIL refresh_done pulses=%0d cycle=%0d exp=1/202", done_cnt, done_cycle); end
        checks++; if (model !== pack_tx()) begin failures++; $display("FAIL refresh_chain got=%h exp=%h", model, pack_tx()); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_round_trip();
        test_backpressure();
        test_gaps_and_start();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
